ysyx_22050598_lsu: RTL and testbench

- Load/store stage directly downstream of the EX/LS pipeline register; consumes its registered outputs and drives one 64-bit data-memory port with a valid/ready request channel and a valid response channel.
- Aligns store data and strobes; extracts and extends load data; stalls the front of the pipeline while a memory access is in flight.
- Presents write-back data combinationally to the LS/WB register.

---
 rtl/ysyx_22050598_lsu_if.sv | 22 ++
 rtl/ysyx_22050598_lsu.sv | 177 +++++++++++++++++
 tb/tb_ysyx_22050598_lsu.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050598_lsu_if.sv
// Data-memory port of the load/store stage: valid/ready request channel
// plus a valid-only response channel carrying read data or a write ack.
interface ysyx_22050598_lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/ysyx_22050598_lsu.sv
// Load/store stage: lane-aligns stores, extracts/extends loads, stalls the
// front end while an access is outstanding and aborts it after a timeout.
module ysyx_22050598_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                ls_alu_rd_ls_data,
  input  logic                       ls_alu_rd_data_en,
  input  logic                       ls_load_en,
  input  logic                       ls_store_en,
  input  logic [63:0]                ls_store_data,
  input  logic [1:0]                 ls_data_type,
  input  logic [4:0]                 ls_rd_idx,
  input  logic                       ls_load_unsigned,
  input  logic                       ls_inst_is_ebreak,
  ysyx_22050598_lsu_if.master        mem,
  output logic                       ls_stall,
  output logic                       ls_wb_valid,
  output logic                       ls_wb_en,
  output logic [4:0]                 ls_wb_rd_idx,
  output logic [63:0]                ls_wb_data,
  output logic                       ls_wb_ebreak,
  output logic                       ls_misalign,
  output logic                       ls_bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  function automatic logic is_misaligned(input logic [1:0] dtype, input logic [2:0] a);
    logic m;
    case (dtype)
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      2'b10:   m = |a[1:0];
      2'b11:   m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] dtype);
    logic [7:0] m;
    case (dtype)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      2'b11:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] f, input logic [1:0] dtype,
                                              input logic uns);
    logic [63:0] r;
    case (dtype)
      2'b00:   r = {{56{~uns & f[7]}}, f[7:0]};
      2'b01:   r = {{48{~uns & f[15]}}, f[15:0]};
      2'b10:   r = {{32{~uns & f[31]}}, f[31:0]};
      2'b11:   r = f;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  sh_s;
  logic        is_load_s, mem_op_s, misalign_s;
  logic [63:0] field_s;
  logic        req_valid_s, stall_s, wb_valid_s, wb_en_s, misalign_out_s, bus_err_s;

  assign sh_s       = ls_alu_rd_ls_data[2:0];
  assign is_load_s  = ls_load_en & ~ls_store_en;
  assign mem_op_s   = ls_load_en | ls_store_en;
  assign misalign_s = is_misaligned(ls_data_type, sh_s);
  assign field_s    = mem.mem_resp_rdata >> {sh_s, 3'b000};

  assign mem.mem_req_we    = ls_store_en;
  assign mem.mem_req_addr  = {ls_alu_rd_ls_data[63:3], 3'b000};
  assign mem.mem_req_wdata = ls_store_data << {sh_s, 3'b000};
  assign mem.mem_req_wstrb = size_mask(ls_data_type) << sh_s;

  // Next-state, timeout counter and raw handshake/write-back qualifiers.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_valid_s    = 1'b0;
    stall_s        = 1'b0;
    wb_valid_s     = 1'b0;
    wb_en_s        = 1'b0;
    misalign_out_s = 1'b0;
    bus_err_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!mem_op_s) begin
          wb_valid_s = 1'b1;
          wb_en_s    = ls_alu_rd_data_en & (ls_rd_idx != 5'd0);
        end else if (misalign_s) begin
          misalign_out_s = 1'b1;
          wb_valid_s     = 1'b1;
        end else begin
          req_valid_s = 1'b1;
          stall_s     = 1'b1;
          if (mem.mem_req_ready) begin
            state_d = S_WAIT;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        req_valid_s = 1'b1;
        stall_s     = 1'b1;
        if (mem.mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        // A response arriving in the timeout cycle still completes the access.
        if (mem.mem_resp_valid) begin
          wb_valid_s = 1'b1;
          wb_en_s    = is_load_s & (ls_rd_idx != 5'd0);
          state_d    = S_IDLE;
          cnt_d      = 8'd0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          bus_err_s  = 1'b1;
          wb_valid_s = 1'b1;
          state_d    = S_IDLE;
          cnt_d      = 8'd0;
        end else begin
          stall_s = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  assign mem.mem_req_valid = req_valid_s & rst;
  assign ls_stall          = stall_s & rst;
  assign ls_wb_valid       = wb_valid_s & rst;
  assign ls_wb_en          = wb_en_s & rst;
  assign ls_misalign       = misalign_out_s & rst;
  assign ls_bus_err        = bus_err_s & rst;
  assign ls_wb_rd_idx      = ls_rd_idx;
  assign ls_wb_data        = is_load_s ? load_extend(field_s, ls_data_type, ls_load_unsigned)
                                       : ls_alu_rd_ls_data;
  assign ls_wb_ebreak      = ls_inst_is_ebreak & ls_wb_valid;

endmodule

// File: tb/tb_ysyx_22050598_lsu.sv
// Randomized self-checking bench for ysyx_22050598_lsu against a byte-level
// reference model of lane placement, load extraction and access timing.
module tb_ysyx_22050598_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_data;
  logic        alu_en, load_en, store_en, load_uns, ebreak;
  logic [63:0] store_data;
  logic [1:0]  dtype;
  logic [4:0]  rd_idx;
  logic        stall, wb_valid, wb_en, wb_ebreak, misalign, bus_err;
  logic [4:0]  wb_rd_idx;
  logic [63:0] wb_data;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22050598_lsu_if bus ();

  ysyx_22050598_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ls_alu_rd_ls_data(alu_data), .ls_alu_rd_data_en(alu_en),
    .ls_load_en(load_en), .ls_store_en(store_en), .ls_store_data(store_data),
    .ls_data_type(dtype), .ls_rd_idx(rd_idx), .ls_load_unsigned(load_uns),
    .ls_inst_is_ebreak(ebreak), .mem(bus.master),
    .ls_stall(stall), .ls_wb_valid(wb_valid), .ls_wb_en(wb_en),
    .ls_wb_rd_idx(wb_rd_idx), .ls_wb_data(wb_data), .ls_wb_ebreak(wb_ebreak),
    .ls_misalign(misalign), .ls_bus_err(bus_err)
  );

  // ---------------- reference model (byte-level) ----------------
  function automatic int size_of(input logic [1:0] t);
    return 1 << t;
  endfunction

  function automatic logic ref_misaligned(input logic [63:0] a, input logic [1:0] t);
    return (a % size_of(t)) != 0;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [63:0] a, input logic [1:0] t);
    logic [7:0] s;
    int sh;
    sh = int'(a % 8);
    s = 8'h00;
    for (int i = 0; i < 8; i++) s[i] = (i >= sh) && (i < sh + size_of(t));
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] a, input logic [63:0] sd);
    logic [63:0] r;
    int sh;
    sh = int'(a % 8);
    r = 64'd0;
    for (int i = 0; i < 8; i++) if (i >= sh) r[8*i +: 8] = sd[8*(i-sh) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] a,
                                           input logic [1:0] t, input logic uns);
    logic [63:0] v;
    int sh, sz;
    sh = int'(a % 8);
    sz = size_of(t);
    v = 64'd0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = rdata[8*(sh+k) +: 8];
    if (!uns && sz < 8 && v[8*sz-1])
      for (int k = sz; k < 8; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input logic [63:0] a, input logic ld, input logic st,
                        input logic [63:0] sd, input logic [1:0] t, input logic uns,
                        input logic [4:0] rd, input logic aen, input logic eb);
    alu_data = a; load_en = ld; store_en = st; store_data = sd; dtype = t;
    load_uns = uns; rd_idx = rd; alu_en = aen; ebreak = eb;
  endtask

  task automatic set_idle();
    set_op(64'd0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = 64'd0;
    set_op(64'h8000_0008, 1'b1, 1'b0, 64'd0, 2'b11, 1'b0, 5'd3, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.mem_req_valid, stall, wb_valid, wb_en, misalign, bus_err, wb_ebreak} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b, want 0000000",
               {bus.mem_req_valid, stall, wb_valid, wb_en, misalign, bus_err, wb_ebreak});
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.mem_req_ready = 1'b0;
    set_idle();
  endtask

  task automatic test_alu(input logic [63:0] a, input logic [4:0] rd, input logic en,
                          input logic eb);
    logic exp_en;
    exp_en = en && (rd != 5'd0);
    @(posedge clk); #1;
    set_op(a, 1'b0, 1'b0, 64'hDEAD, 2'b11, 1'b0, rd, en, eb);
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req_valid, stall, wb_valid, wb_en, misalign, bus_err, wb_ebreak} !==
        {4'b0010 | {3'b000, exp_en}, 2'b00, eb}) begin
      n_errors++;
      $display("FAIL alu_ctrl: got %b, want %b",
               {bus.mem_req_valid, stall, wb_valid, wb_en, misalign, bus_err, wb_ebreak},
               {4'b0010 | {3'b000, exp_en}, 2'b00, eb});
    end
    n_checks++;
    if ({wb_data, wb_rd_idx} !== {a, rd}) begin
      n_errors++;
      $display("FAIL alu_data: got %h/%0d, want %h/%0d", wb_data, wb_rd_idx, a, rd);
    end
  endtask

  task automatic run_mem(input logic [63:0] a, input logic ld, input logic st,
                         input logic [63:0] sd, input logic [1:0] t, input logic uns,
                         input logic [4:0] rd, input logic eb, input int rdly, input int wdly,
                         input logic [63:0] rdata, input logic early);
    logic [63:0] exp_w, exp_l;
    logic [7:0]  exp_s;
    logic        exp_en;
    exp_w  = ref_wdata(a, sd);
    exp_s  = ref_strb(a, t);
    exp_l  = ref_load(rdata, a, t, uns);
    exp_en = !st && (rd != 5'd0);
    @(posedge clk); #1;
    set_op(a, ld, st, sd, t, uns, rd, 1'b1, eb);
    for (int c = 0; c <= rdly; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus.mem_req_ready  = (c == rdly);
      bus.mem_resp_valid = early && (c == rdly);
      bus.mem_resp_rdata = ~rdata;
      @(negedge clk);
      n_checks++;
      if ({bus.mem_req_valid, stall, wb_valid, wb_ebreak} !== 4'b1100) begin
        n_errors++;
        $display("FAIL req_ctrl: got %b, want 1100", {bus.mem_req_valid, stall, wb_valid, wb_ebreak});
      end
      n_checks++;
      if ({bus.mem_req_we, bus.mem_req_addr} !== {st, a & ~64'h7}) begin
        n_errors++;
        $display("FAIL req_addr: got %b/%h, want %b/%h", bus.mem_req_we, bus.mem_req_addr,
                 st, a & ~64'h7);
      end
      if (st) begin
        n_checks++;
        if ({bus.mem_req_wstrb, bus.mem_req_wdata} !== {exp_s, exp_w}) begin
          n_errors++;
          $display("FAIL req_lane: got %h/%h, want %h/%h", bus.mem_req_wstrb, bus.mem_req_wdata,
                   exp_s, exp_w);
        end
      end
    end
    for (int w = 0; w <= wdly; w++) begin
      @(posedge clk); #1;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = (w == wdly);
      bus.mem_resp_rdata = rdata;
      @(negedge clk);
      n_checks++;
      if (w < wdly) begin
        if ({bus.mem_req_valid, stall, wb_valid, wb_ebreak} !== 4'b0100) begin
          n_errors++;
          $display("FAIL wait_ctrl: got %b, want 0100", {bus.mem_req_valid, stall, wb_valid, wb_ebreak});
        end
      end else begin
        if ({bus.mem_req_valid, stall, wb_valid, wb_en, bus_err, wb_ebreak} !==
            {3'b001, exp_en, 1'b0, eb}) begin
          n_errors++;
          $display("FAIL resp_ctrl: got %b, want %b",
                   {bus.mem_req_valid, stall, wb_valid, wb_en, bus_err, wb_ebreak},
                   {3'b001, exp_en, 1'b0, eb});
        end
        if (!st) begin
          n_checks++;
          if (wb_data !== exp_l) begin
            n_errors++;
            $display("FAIL load_data: got %h, want %h", wb_data, exp_l);
          end
        end
      end
    end
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    set_idle();
  endtask

  task automatic test_misalign(input logic [63:0] a, input logic ld, input logic st,
                               input logic [1:0] t);
    @(posedge clk); #1;
    set_op(a, ld, st, 64'h1234_5678, t, 1'b0, 5'd7, 1'b1, 1'b0);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req_valid, stall, wb_valid, wb_en, misalign} !== 5'b00101) begin
      n_errors++;
      $display("FAIL misalign_ctrl: got %b, want 00101", {bus.mem_req_valid, stall, wb_valid, wb_en, misalign});
    end
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    set_idle();
    @(negedge clk);
    n_checks++;
    if ({misalign, stall} !== 2'b00) begin
      n_errors++;
      $display("FAIL misalign_pulse: got %b, want 00", {misalign, stall});
    end
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    set_op(64'h8000_0010, 1'b1, 1'b0, 64'd0, 2'b11, 1'b0, 5'd9, 1'b0, 1'b0);
    bus.mem_req_ready = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (w < 4) begin
        if ({stall, wb_valid, bus_err} !== 3'b100) begin
          n_errors++;
          $display("FAIL timeout_wait%0d: got %b, want 100", w, {stall, wb_valid, bus_err});
        end
      end else if ({bus.mem_req_valid, stall, wb_valid, wb_en, bus_err} !== 5'b00101) begin
        n_errors++;
        $display("FAIL timeout_abort: got %b, want 00101", {bus.mem_req_valid, stall, wb_valid, wb_en, bus_err});
      end
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if ({bus_err, stall} !== 2'b00) begin
      n_errors++;
      $display("FAIL timeout_pulse: got %b, want 00", {bus_err, stall});
    end
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req_valid, stall, wb_valid, wb_en, bus_err} !== 5'b00100) begin
      n_errors++;
      $display("FAIL stray_resp: got %b, want 00100", {bus.mem_req_valid, stall, wb_valid, wb_en, bus_err});
    end
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    set_op(64'h8000_0020, 1'b1, 1'b0, 64'd0, 2'b11, 1'b0, 5'd4, 1'b0, 1'b0);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("FAIL rstwait_pre: got stall %b, want 1", stall);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req_valid, stall, wb_valid, bus_err, misalign} !== 5'b0) begin
      n_errors++;
      $display("FAIL rstwait_async: got %b, want 00000", {bus.mem_req_valid, stall, wb_valid, bus_err, misalign});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    set_op(64'h0000_0000_0BAD_F00D, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 5'd12, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({stall, wb_valid, wb_en, wb_data} !== {3'b011, 64'h0BAD_F00D}) begin
      n_errors++;
      $display("FAIL rstwait_after: got %b/%h, want 011/%h", {stall, wb_valid, wb_en}, wb_data,
               64'h0BAD_F00D);
    end
  endtask

  task automatic test_random_alu(input int n);
    for (int i = 0; i < n; i++)
      test_alu({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_random_mem(input int n);
    logic [1:0] t;
    logic       ld, st;
    int         off, sz;
    for (int i = 0; i < n; i++) begin
      t  = 2'($urandom_range(0, 3));
      sz = size_of(t);
      off = $urandom_range(0, 4095);
      off = off - (off % sz);
      case ($urandom_range(0, 3))
        0:       begin ld = 1'b1; st = 1'b1; end
        1:       begin ld = 1'b0; st = 1'b1; end
        default: begin ld = 1'b1; st = 1'b0; end
      endcase
      run_mem(64'h8000_0000 + 64'(off), ld, st, {$urandom, $urandom}, t, 1'($urandom),
              5'($urandom_range(0, 31)), 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 2), {$urandom, $urandom}, 1'($urandom));
    end
  endtask

  task automatic test_random_misalign(input int n);
    logic [1:0] t;
    int         off, sz;
    for (int i = 0; i < n; i++) begin
      t   = 2'($urandom_range(1, 3));
      sz  = size_of(t);
      off = $urandom_range(0, 4095);
      off = off - (off % sz) + $urandom_range(1, sz - 1);
      if (ref_misaligned(64'(off), t)) test_misalign(64'h8000_0000 + 64'(off), 1'($urandom), 1'b1, t);
      else test_misalign(64'h8000_0000 + 64'(off), 1'b1, 1'b0, t);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu(64'h1234, 5'd5, 1'b1, 1'b0);
    test_alu(64'h55AA, 5'd0, 1'b1, 1'b1);
    test_random_alu(10);
    run_mem(64'h8000_0003, 1'b1, 1'b0, 64'd0, 2'b00, 1'b0, 5'd6, 1'b0, 0, 0,
            64'h0000_0000_8000_0000, 1'b0);
    run_mem(64'h8000_0003, 1'b1, 1'b0, 64'd0, 2'b00, 1'b1, 5'd6, 1'b0, 0, 0,
            64'h0000_0000_8000_0000, 1'b0);
    run_mem(64'h8000_0006, 1'b0, 1'b1, 64'hABCD, 2'b01, 1'b0, 5'd8, 1'b0, 3, 0,
            64'd0, 1'b1);
    test_misalign(64'h8000_0002, 1'b1, 1'b0, 2'b10);
    test_random_mem(24);
    test_random_misalign(6);
    test_timeout();
    test_alu(64'hCAFE, 5'd1, 1'b1, 1'b0);
    test_reset_in_wait();
    test_random_mem(6);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
